// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator for a word-addressed data memory with 1-cycle read latency.
// Sub-word stores are performed as read-modify-write because the memory only writes full words.
module load_store_unit #(
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_err;
  logic [4:0]  lane_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] store_mask;
  logic [31:0] merged_word;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(NUM_WORDS)) req_err = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores share one shift amount.
  assign lane_shift = {offset_q, 3'b000};
  assign lane_byte  = mem_rdata[lane_shift +: 8];
  assign lane_half  = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  assign store_mask  = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
  assign merged_word = (mem_rdata & ~store_mask) | ((wdata_q << lane_shift) & store_mask);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    mem_read_d  = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          offset_d = req_addr[1:0];
          wdata_d  = req_wdata;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d    = ISSUE;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_funct3 == 3'b010)) begin
              mem_wr_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              mem_read_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q && (funct3_q[1:0] == 2'b10)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (we_q) begin
          state_d     = WRITE;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merged_word;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data;
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      wdata_q     <= 32'h0;
      mem_read_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_read  = mem_read_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a 32-word registered-read memory model.
// Cycle numbers count rising edges after the accepting edge; outputs are sampled on falling edges.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:31];
  logic [31:0] mem_snap [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_data = 32'h0;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int rsp_cnt = 0;
  int accept_cnt = 0;
  int n_checks = 0;
  int n_passed = 0;

  int          obs_rd_cyc, obs_wr_cyc, obs_rsp_cyc;
  logic [31:0] obs_wr_addr, obs_wr_data, obs_rdata;
  logic        obs_err;

  load_store_unit #(.NUM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_read) mem_rdata <= mem[mem_addr[6:2]];
    if (mem_wr) mem[mem_addr[6:2]] <= mem_wdata;
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_wr) wr_cnt <= wr_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (req_valid && req_ready && !rst) accept_cnt <= accept_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request and records when memory strobes and the response appear.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    obs_rd_cyc = -1; obs_wr_cyc = -1; obs_rsp_cyc = -1;
    obs_wr_addr = 32'h0; obs_wr_data = 32'h0; obs_rdata = 32'h0; obs_err = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_read && obs_rd_cyc < 0) obs_rd_cyc = c;
      if (mem_wr && obs_wr_cyc < 0) begin
        obs_wr_cyc = c; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata;
      end
      if (rsp_valid) begin
        obs_rsp_cyc = c; obs_rdata = rsp_rdata; obs_err = rsp_err;
        break;
      end
    end
  endtask

  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp_data);
    applyStimulus(1'b0, f3, addr, 32'h0);
    checkOutput({tag, "_rdata"}, obs_rdata, exp_data);
    checkOutput({tag, "_rsp_cyc"}, 32'(obs_rsp_cyc), 32'd3);
    checkOutput({tag, "_err"}, 32'(obs_err), 32'd0);
  endtask

  task automatic runError(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int ops0;
    ops0 = rd_cnt + wr_cnt;
    applyStimulus(we, f3, addr, 32'hFFFF_FFFF);
    checkOutput({tag, "_rsp_cyc"}, 32'(obs_rsp_cyc), 32'd1);
    checkOutput({tag, "_err"}, 32'(obs_err), 32'd1);
    checkOutput({tag, "_rdata"}, obs_rdata, 32'h0);
    checkOutput({tag, "_rd_cyc"}, 32'(obs_rd_cyc), 32'hFFFF_FFFF);
    checkOutput({tag, "_wr_cyc"}, 32'(obs_wr_cyc), 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_mem_ops"}, 32'(rd_cnt + wr_cnt - ops0), 32'd0);
  endtask

  initial begin
    int acc0, wr0, rsp0, diffs, c;
    logic ready_low_ok;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    applyStimulus(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
    checkOutput("sw_wr_cyc", 32'(obs_wr_cyc), 32'd1);
    checkOutput("sw_wr_addr", obs_wr_addr, 32'h08);
    checkOutput("sw_wr_data", obs_wr_data, 32'hDEAD_BEEF);
    checkOutput("sw_rd_cyc", 32'(obs_rd_cyc), 32'hFFFF_FFFF);
    checkOutput("sw_rsp_cyc", 32'(obs_rsp_cyc), 32'd2);
    checkOutput("sw_rdata", obs_rdata, 32'h0);
    @(negedge clk);
    checkOutput("sw_mem_word", mem[2], 32'hDEAD_BEEF);

    applyStimulus(1'b0, 3'b010, 32'h08, 32'h0);
    checkOutput("lw_rd_cyc", 32'(obs_rd_cyc), 32'd1);
    checkOutput("lw_rsp_cyc", 32'(obs_rsp_cyc), 32'd3);
    checkOutput("lw_rdata", obs_rdata, 32'hDEAD_BEEF);
    checkOutput("lw_err", 32'(obs_err), 32'd0);

    preload(5'd4, 32'h8081_7F01);
    runLoad("lb_13", 3'b000, 32'h13, 32'hFFFF_FF80);
    runLoad("lbu_13", 3'b100, 32'h13, 32'h0000_0080);
    runLoad("lb_11", 3'b000, 32'h11, 32'h0000_007F);
    runLoad("lh_12", 3'b001, 32'h12, 32'hFFFF_8081);
    runLoad("lhu_12", 3'b101, 32'h12, 32'h0000_8081);
    runLoad("lh_10", 3'b001, 32'h10, 32'h0000_7F01);

    preload(5'd8, 32'h1122_3344);
    applyStimulus(1'b1, 3'b000, 32'h21, 32'h0000_00AB);
    checkOutput("sb_rd_cyc", 32'(obs_rd_cyc), 32'd1);
    checkOutput("sb_wr_cyc", 32'(obs_wr_cyc), 32'd3);
    checkOutput("sb_wr_addr", obs_wr_addr, 32'h20);
    checkOutput("sb_wr_data", obs_wr_data, 32'h1122_AB44);
    checkOutput("sb_rsp_cyc", 32'(obs_rsp_cyc), 32'd4);
    checkOutput("sb_err", 32'(obs_err), 32'd0);

    applyStimulus(1'b1, 3'b001, 32'h22, 32'h1234_CDEF);
    checkOutput("sh_wr_data", obs_wr_data, 32'hCDEF_AB44);
    checkOutput("sh_rsp_cyc", 32'(obs_rsp_cyc), 32'd4);
    @(negedge clk);
    checkOutput("sh_mem_word", mem[8], 32'hCDEF_AB44);

    for (int i = 0; i < 32; i++) mem_snap[i] = mem[i];
    runError("err_lw_06", 1'b0, 3'b010, 32'h06);
    runError("err_sh_05", 1'b1, 3'b001, 32'h05);
    runError("err_lb_f3_011", 1'b0, 3'b011, 32'h10);
    runError("err_sw_80", 1'b1, 3'b010, 32'h80);
    runError("err_store_f3_100", 1'b1, 3'b100, 32'h10);
    diffs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== mem_snap[i]) diffs++;
    checkOutput("err_mem_unchanged", 32'(diffs), 32'd0);

    // Backpressure: valid stays high across a load while the fields change underneath it.
    @(negedge clk);
    acc0 = accept_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = 32'h0;
    @(posedge clk);
    ready_low_ok = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_funct3 = 3'b100; req_addr = 32'h13;
      end
      if (req_ready) ready_low_ok = 1'b0;
      if (k == 3) begin
        checkOutput("bp_first_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_first_rdata", rsp_rdata, 32'hDEAD_BEEF);
      end
    end
    checkOutput("bp_ready_low", 32'(ready_low_ok), 32'd1);
    @(negedge clk);
    checkOutput("bp_ready_cyc4", 32'(req_ready), 32'd1);
    @(posedge clk);
    c = -1;
    for (int k = 5; k <= 25; k++) begin
      @(negedge clk);
      if (k == 5) req_valid = 1'b0;
      if (rsp_valid) begin
        c = k;
        checkOutput("bp_second_rdata", rsp_rdata, 32'h0000_0080);
        break;
      end
    end
    checkOutput("bp_second_rsp_cyc", 32'(c), 32'd7);
    repeat (2) @(negedge clk);
    checkOutput("bp_accept_count", 32'(accept_cnt - acc0), 32'd2);

    // Reset during the CAPTURE cycle of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    wr0 = wr_cnt; rsp0 = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rmw_rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rmw_rst_mem_wr", 32'(mem_wr), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("rmw_rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    checkOutput("rmw_rst_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    checkOutput("rmw_rst_word", mem[8], 32'hCDEF_AB44);

    runLoad("lw_after_rst", 3'b010, 32'h20, 32'hCDEF_AB44);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
